// File: rtl/vscale_scoreboard_pkg.sv
// vscale_scoreboard_pkg: shared scoreboard defaults and the occupancy-counter width helper.
package vscale_scoreboard_pkg;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_DEPTH = 4;
  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/vscale_scoreboard_if.sv
// vscale_scoreboard_if: DX issue, completion bus, flush and status signals of the scoreboard.
interface vscale_scoreboard_if #(
  parameter int AW = 5,
  parameter int CW = 3
);
  logic          issue_valid;
  logic          issue_wr;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          uses_rs1;
  logic          uses_rs2;
  logic          issue_stall;
  logic          bypass_rs1;
  logic          bypass_rs2;
  logic          cmpl_valid;
  logic [AW-1:0] cmpl_rd;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          protocol_err;
  modport master (
    output issue_valid, issue_wr, issue_rd, rs1_addr, rs2_addr, uses_rs1, uses_rs2,
    output cmpl_valid, cmpl_rd, flush,
    input  issue_stall, bypass_rs1, bypass_rs2, full, empty, count, protocol_err
  );
  modport slave (
    input  issue_valid, issue_wr, issue_rd, rs1_addr, rs2_addr, uses_rs1, uses_rs2,
    input  cmpl_valid, cmpl_rd, flush,
    output issue_stall, bypass_rs1, bypass_rs2, full, empty, count, protocol_err
  );
endinterface

// File: rtl/vscale_sb_fifo.sv
// vscale_sb_fifo: in-order queue of pending destination registers; flush empties it.
module vscale_sb_fifo
  import vscale_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = 5,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = sb_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [AW-1:0] wdata_i,
  output logic [AW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_comb begin
    wptr_d = flush_i ? '0 : wptr_q + PW'(do_push);
    rptr_d = flush_i ? '0 : rptr_q + PW'(do_pop);
    cnt_d  = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
endmodule

// File: rtl/vscale_scoreboard.sv
// vscale_scoreboard: RAW/WAW/capacity interlock for long-latency writes.
// Define VSCALE_SB_BYPASS_EN to let a source read the same-cycle completion bus.
module vscale_scoreboard
  import vscale_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int DEPTH = SB_DEPTH,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = sb_cnt_w(DEPTH)
) (
  input logic clk,
  input logic reset,
  vscale_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0] pend_q, pend_d, pend_eff, retire, set_bit;
  logic [AW-1:0] head;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  logic err_q, err_d;
  logic pop_ok, want_push, push, raw1, raw2, waw, stall;
  vscale_sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop_ok), .flush_i(sb.flush),
    .wdata_i(sb.issue_rd), .head_o(head), .full_o(fifo_full), .empty_o(fifo_empty),
    .count_o(fifo_count)
  );
  // A completion retires only if it names the oldest pending write.
  assign pop_ok    = sb.cmpl_valid && !fifo_empty && sb.cmpl_rd == head;
  assign retire    = NUM_REGS'(pop_ok) << sb.cmpl_rd;
  assign want_push = sb.issue_valid && sb.issue_wr && sb.issue_rd != '0;
  assign push      = want_push && !stall;
  assign set_bit   = NUM_REGS'(push) << sb.issue_rd;
`ifdef VSCALE_SB_BYPASS_EN
  assign pend_eff      = pend_q & ~retire;
  assign sb.bypass_rs1 = sb.uses_rs1 && sb.rs1_addr != '0 && retire[sb.rs1_addr];
  assign sb.bypass_rs2 = sb.uses_rs2 && sb.rs2_addr != '0 && retire[sb.rs2_addr];
`else
  assign pend_eff      = pend_q;
  assign sb.bypass_rs1 = 1'b0;
  assign sb.bypass_rs2 = 1'b0;
`endif
  always_comb begin
    raw1   = sb.uses_rs1 && sb.rs1_addr != '0 && pend_eff[sb.rs1_addr];
    raw2   = sb.uses_rs2 && sb.rs2_addr != '0 && pend_eff[sb.rs2_addr];
    waw    = sb.issue_wr && sb.issue_rd != '0 && pend_q[sb.issue_rd] &&
             !(pop_ok && sb.cmpl_rd == sb.issue_rd);
    stall  = sb.issue_valid && (raw1 || raw2 || waw || (fifo_full && want_push && !pop_ok));
    pend_d = sb.flush ? '0 : (pend_q & ~retire) | set_bit;
    err_d  = err_q || (sb.cmpl_valid && (fifo_empty || sb.cmpl_rd != head));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
  assign sb.issue_stall  = stall;
  assign sb.full         = fifo_full;
  assign sb.empty        = fifo_empty;
  assign sb.count        = fifo_count;
  assign sb.protocol_err = err_q;
endmodule

// File: tb/tb_vscale_scoreboard.sv
// tb_vscale_scoreboard: directed checks of hazards, capacity, flush and completion-protocol errors.
module tb_vscale_scoreboard;
`ifdef VSCALE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  vscale_scoreboard_if #(.AW(5), .CW(3)) ifc ();
  vscale_scoreboard #(.NUM_REGS(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .sb(ifc));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ifc.issue_valid = 0; ifc.issue_wr = 0; ifc.issue_rd = 0;
    ifc.rs1_addr = 0; ifc.rs2_addr = 0; ifc.uses_rs1 = 0; ifc.uses_rs2 = 0;
    ifc.cmpl_valid = 0; ifc.cmpl_rd = 0; ifc.flush = 0;
  endtask

  task automatic wr(input logic [4:0] rd);
    ifc.issue_valid = 1; ifc.issue_wr = 1; ifc.issue_rd = rd;
  endtask

  task automatic cm(input logic [4:0] rd);
    ifc.cmpl_valid = 1; ifc.cmpl_rd = rd;
  endtask

  initial begin
    clr();
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_count", 32'(ifc.count), 0);
    chk("rst_empty", 32'(ifc.empty), 1);
    chk("rst_full", 32'(ifc.full), 0);
    chk("rst_perr", 32'(ifc.protocol_err), 0);
    chk("rst_stall", 32'(ifc.issue_stall), 0);
    // RAW on x5 until its completion
    wr(5); #1;
    chk("raw_wr_stall", 32'(ifc.issue_stall), 0);
    tick(); clr();
    chk("raw_cnt", 32'(ifc.count), 1);
    ifc.issue_valid = 1; ifc.uses_rs1 = 1; ifc.rs1_addr = 5; #1;
    chk("raw_stall0", 32'(ifc.issue_stall), 1);
    tick();
    chk("raw_stall1", 32'(ifc.issue_stall), 1);
    cm(5); #1;
    chk("raw_cmpl_stall", 32'(ifc.issue_stall), 32'(!BYP));
    chk("raw_cmpl_byp", 32'(ifc.bypass_rs1), 32'(BYP));
    chk("raw_cmpl_byp2", 32'(ifc.bypass_rs2), 0);
    tick();
    chk("raw_cnt0", 32'(ifc.count), 0);
    ifc.cmpl_valid = 0; #1;
    chk("raw_after_stall", 32'(ifc.issue_stall), 0);
    chk("raw_after_byp", 32'(ifc.bypass_rs1), 0);
    tick(); clr();
    // x0 never tracked
    wr(0); ifc.uses_rs1 = 1; ifc.rs1_addr = 0; #1;
    chk("x0_stall", 32'(ifc.issue_stall), 0);
    tick(); clr();
    chk("x0_count", 32'(ifc.count), 0);
    chk("x0_empty", 32'(ifc.empty), 1);
    // capacity: fill x1..x4, fifth write stalls unless head retires
    for (int r = 1; r <= 4; r++) begin
      wr(5'(r)); tick();
    end
    clr(); #1;
    chk("cap_count", 32'(ifc.count), 4);
    chk("cap_full", 32'(ifc.full), 1);
    wr(6); #1;
    chk("cap_stall", 32'(ifc.issue_stall), 1);
    cm(1); #1;
    chk("cap_pop_stall", 32'(ifc.issue_stall), 0);
    tick(); clr();
    chk("cap_count_after", 32'(ifc.count), 4);
    chk("cap_full_after", 32'(ifc.full), 1);
    ifc.issue_valid = 1; ifc.uses_rs1 = 1; ifc.rs1_addr = 6; #1;
    chk("cap_x6_pending", 32'(ifc.issue_stall), 1);
    clr();
    cm(2); tick(); cm(3); tick(); cm(4); tick(); cm(6); tick(); clr();
    chk("cap_drain_count", 32'(ifc.count), 0);
    chk("cap_drain_perr", 32'(ifc.protocol_err), 0);
    // WAW on x7
    wr(7); tick(); clr();
    wr(7); #1;
    chk("waw_stall", 32'(ifc.issue_stall), 1);
    cm(7); #1;
    chk("waw_cmpl_stall", 32'(ifc.issue_stall), 0);
    tick(); clr();
    chk("waw_count", 32'(ifc.count), 1);
    wr(7); #1;
    chk("waw_repend", 32'(ifc.issue_stall), 1);
    clr(); cm(7); tick(); clr();
    chk("waw_count0", 32'(ifc.count), 0);
    // flush beats simultaneous completion and issue
    wr(1); tick(); wr(2); tick(); wr(3); tick(); clr();
    chk("fl_count3", 32'(ifc.count), 3);
    ifc.flush = 1; cm(1); wr(8); tick(); clr();
    chk("fl_count", 32'(ifc.count), 0);
    chk("fl_empty", 32'(ifc.empty), 1);
    ifc.issue_valid = 1; ifc.uses_rs1 = 1; ifc.rs1_addr = 2;
    ifc.uses_rs2 = 1; ifc.rs2_addr = 8; #1;
    chk("fl_no_pend_raw", 32'(ifc.issue_stall), 0);
    clr(); wr(3); #1;
    chk("fl_no_pend_waw", 32'(ifc.issue_stall), 0);
    clr();
    // completion protocol errors
    cm(4); tick(); clr();
    chk("pe_empty", 32'(ifc.protocol_err), 1);
    chk("pe_empty_cnt", 32'(ifc.count), 0);
    tick();
    chk("pe_sticky", 32'(ifc.protocol_err), 1);
    wr(3); tick(); clr();
    cm(9); tick(); clr();
    chk("pe_wrong_cnt", 32'(ifc.count), 1);
    ifc.issue_valid = 1; ifc.uses_rs2 = 1; ifc.rs2_addr = 3; #1;
    chk("pe_x3_still_pend", 32'(ifc.issue_stall), 1);
    ifc.uses_rs2 = 0; #1;
    chk("rs2_unused", 32'(ifc.issue_stall), 0);
    clr(); cm(3); tick(); clr();
    chk("pe_pop_cnt", 32'(ifc.count), 0);
    chk("pe_still", 32'(ifc.protocol_err), 1);
    // reset clears sticky error and state, overriding activity
    wr(10); reset = 1; tick(); reset = 0; clr(); #1;
    chk("rst2_perr", 32'(ifc.protocol_err), 0);
    chk("rst2_count", 32'(ifc.count), 0);
    ifc.issue_valid = 1; ifc.uses_rs1 = 1; ifc.rs1_addr = 10; #1;
    chk("rst2_no_pend", 32'(ifc.issue_stall), 0);
    clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
